// File: rtl/edge_enhancement_regbank_pkg.sv
// Shared types and constants for the edge_enhancement AXI4-Lite register bank.
// Covers the register modes, the AXI response codes and the write/read FSM states.
package edge_enhancement_regbank_pkg;

  typedef enum logic [1:0] {
    MODE_RW  = 2'b00,
    MODE_RO  = 2'b01,
    MODE_W1C = 2'b10
  } reg_mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_e;

  // Expands up to eight byte strobes into a 64-bit bit mask.
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    for (int b = 0; b < 8; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/edge_enhancement_reg_cell.sv
// One bank register: RW byte merge, RO passthrough for reads, or W1C event flags
// that collect hw_set every cycle and give hw_set priority over a same-bit clear.
module edge_enhancement_reg_cell
  import edge_enhancement_regbank_pkg::*;
#(
  parameter int              DW        = 32,
  parameter logic [1:0]      MODE      = 2'b00,
  parameter logic [DW-1:0]   RESET_VAL = {DW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DW-1:0]    wdata,
  input  logic [DW/8-1:0]  wstrb,
  input  logic [DW-1:0]    hw_in,
  input  logic [DW-1:0]    hw_set,
  output logic [DW-1:0]    q,
  output logic [DW-1:0]    rd,
  output logic             wr_pulse
);

  logic [DW-1:0] val_r;
  logic [DW-1:0] val_nxt_s;
  logic [DW-1:0] mask_s;
  logic          pulse_r;
  logic          pulse_nxt_s;

  // Next register value and write pulse for the configured mode.
  always_comb begin
    mask_s      = DW'(strb_to_mask(8'(wstrb)));
    val_nxt_s   = val_r;
    pulse_nxt_s = 1'b0;
    case (MODE)
      MODE_RW: begin
        if (wr_en) begin
          val_nxt_s   = (val_r & ~mask_s) | (wdata & mask_s);
          pulse_nxt_s = 1'b1;
        end else begin
          val_nxt_s   = val_r;
          pulse_nxt_s = 1'b0;
        end
      end
      MODE_W1C: begin
        if (wr_en) begin
          val_nxt_s   = (val_r & ~(wdata & mask_s)) | hw_set;
          pulse_nxt_s = 1'b1;
        end else begin
          val_nxt_s   = val_r | hw_set;
          pulse_nxt_s = 1'b0;
        end
      end
      MODE_RO: begin
        val_nxt_s   = {DW{1'b0}};
        pulse_nxt_s = 1'b0;
      end
      default: begin
        val_nxt_s   = val_r;
        pulse_nxt_s = 1'b0;
      end
    endcase
  end

  // Register storage; RO slots hold zero so reg_q reads back 0 for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r   <= (MODE == MODE_RO) ? {DW{1'b0}} : RESET_VAL;
      pulse_r <= 1'b0;
    end else begin
      val_r   <= val_nxt_s;
      pulse_r <= pulse_nxt_s;
    end
  end

  assign q        = val_r;
  assign rd       = (MODE == MODE_RO) ? hw_in : val_r;
  assign wr_pulse = pulse_r;

endmodule

// File: rtl/edge_enhancement_regbank.sv
// AXI4-Lite slave register bank for the edge_enhancement datapath: independent AW/W
// ordering, one outstanding write and read, SLVERR on unmapped indices.
module edge_enhancement_regbank
  import edge_enhancement_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS           = 8,
  parameter logic [2*NUM_REGS-1:0] REG_MODE = 16'h9000,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = {(NUM_REGS*C_S_AXI_DATA_WIDTH){1'b0}}
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int OFFW = $clog2(DW/8);
  localparam int IDXW = C_S_AXI_ADDR_WIDTH - OFFW;
  localparam logic [IDXW:0] NREGS_W = (IDXW+1)'(NUM_REGS);

  wstate_e            wstate_r, wstate_nxt_s;
  logic               awready_r, wready_r, bvalid_r;
  logic [1:0]         bresp_r;
  logic [IDXW-1:0]    aw_idx_r;
  logic [DW-1:0]      wdata_r;
  logic [DW/8-1:0]    wstrb_r;
  logic               aw_hs_s, w_hs_s, commit_s, c_mapped_s;
  logic [IDXW-1:0]    c_idx_s;
  logic [DW-1:0]      c_data_s;
  logic [DW/8-1:0]    c_strb_s;
  logic [NUM_REGS-1:0] wr_en_s;

  rstate_e            rstate_r, rstate_nxt_s;
  logic               arready_r, rvalid_r, ar_hs_s, ar_mapped_s;
  logic [1:0]         rresp_r;
  logic [DW-1:0]      rdata_r, rsel_s;
  logic [IDXW-1:0]    ar_idx_s;
  logic [DW-1:0]      rd_arr [NUM_REGS];

  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFFW-1:0], S_AXI_ARADDR[OFFW-1:0]};

  // Write FSM next state and commit; the commit uses whichever beat is still live.
  always_comb begin
    aw_hs_s      = S_AXI_AWVALID & awready_r;
    w_hs_s       = S_AXI_WVALID & wready_r;
    wstate_nxt_s = wstate_r;
    commit_s     = 1'b0;
    case (wstate_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          wstate_nxt_s = W_RESP;
          commit_s     = 1'b1;
        end else if (aw_hs_s) begin
          wstate_nxt_s = W_HAVE_ADDR;
        end else if (w_hs_s) begin
          wstate_nxt_s = W_HAVE_DATA;
        end else begin
          wstate_nxt_s = W_IDLE;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) begin
          wstate_nxt_s = W_RESP;
          commit_s     = 1'b1;
        end else begin
          wstate_nxt_s = W_HAVE_ADDR;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) begin
          wstate_nxt_s = W_RESP;
          commit_s     = 1'b1;
        end else begin
          wstate_nxt_s = W_HAVE_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_nxt_s = W_IDLE;
        end else begin
          wstate_nxt_s = W_RESP;
        end
      end
      default: wstate_nxt_s = W_IDLE;
    endcase
    c_idx_s    = (wstate_r == W_HAVE_ADDR) ? aw_idx_r : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFFW];
    c_data_s   = (wstate_r == W_HAVE_DATA) ? wdata_r : S_AXI_WDATA;
    c_strb_s   = (wstate_r == W_HAVE_DATA) ? wstrb_r : S_AXI_WSTRB;
    c_mapped_s = ({1'b0, c_idx_s} < NREGS_W);
    wr_en_s    = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_en_s[i] = commit_s & c_mapped_s & (c_idx_s == IDXW'(i));
    end
  end

  // Write state register; READY/VALID are registered from the next state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wstate_r  <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      wstate_r  <= wstate_nxt_s;
      awready_r <= (wstate_nxt_s == W_IDLE) || (wstate_nxt_s == W_HAVE_DATA);
      wready_r  <= (wstate_nxt_s == W_IDLE) || (wstate_nxt_s == W_HAVE_ADDR);
      bvalid_r  <= (wstate_nxt_s == W_RESP);
      if (commit_s) begin
        bresp_r <= c_mapped_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Holds whichever beat arrived first until its partner shows up.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_idx_r <= {IDXW{1'b0}};
      wdata_r  <= {DW{1'b0}};
      wstrb_r  <= {(DW/8){1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFFW];
      end
      if (w_hs_s) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    edge_enhancement_reg_cell #(
      .DW        (DW),
      .MODE      (REG_MODE[2*gi +: 2]),
      .RESET_VAL (RESET_VAL[gi*DW +: DW])
    ) u_cell (
      .clk      (S_AXI_ACLK),
      .rst      (S_AXI_ARESET),
      .wr_en    (wr_en_s[gi]),
      .wdata    (c_data_s),
      .wstrb    (c_strb_s),
      .hw_in    (hw_in[gi*DW +: DW]),
      .hw_set   (hw_set[gi*DW +: DW]),
      .q        (reg_q[gi*DW +: DW]),
      .rd       (rd_arr[gi]),
      .wr_pulse (wr_pulse[gi])
    );
  end

  // Read FSM next state and read mux; the mux sees pre-commit register values.
  always_comb begin
    ar_hs_s     = S_AXI_ARVALID & arready_r;
    ar_idx_s    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:OFFW];
    ar_mapped_s = ({1'b0, ar_idx_s} < NREGS_W);
    rsel_s      = {DW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rsel_s = rsel_s | ({DW{ar_idx_s == IDXW'(i)}} & rd_arr[i]);
    end
    case (rstate_r)
      R_IDLE:  rstate_nxt_s = ar_hs_s ? R_RESP : R_IDLE;
      R_RESP:  rstate_nxt_s = S_AXI_RREADY ? R_IDLE : R_RESP;
      default: rstate_nxt_s = R_IDLE;
    endcase
  end

  // Read state register and captured read response.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rstate_r  <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      rresp_r   <= RESP_OKAY;
    end else begin
      rstate_r  <= rstate_nxt_s;
      arready_r <= (rstate_nxt_s == R_IDLE);
      rvalid_r  <= (rstate_nxt_s == R_RESP);
      if (ar_hs_s) begin
        rdata_r <= ar_mapped_s ? rsel_s : {DW{1'b0}};
        rresp_r <= ar_mapped_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;

endmodule
